// File: rtl/key_debounce.sv
// key_debounce
//   Synchronises a raw asynchronous level into the sclk domain. It accepts a new
//   level only after the level has held for DEB_CYCLES consecutive synchronised
//   samples, and drives the clean level on o_data_stable.
//
//   Ports:
//     sclk           in   system clock
//     rst_n          in   asynchronous, active-low reset
//     i_data_in      in   raw asynchronous level
//     o_data_stable  out  debounced level (registered)
//     o_valid_chg    out  one-cycle pulse in the cycle o_data_stable toggles
//     o_busy         out  high while a candidate change is being qualified
//     o_evt_cnt      out  [7:0] accepted-change counter, wraps 255 -> 0
//                         (present only when DEBOUNCE_EVT_CNT_EN is defined)
//
//   Optional feature macro: DEBOUNCE_EVT_CNT_EN
//
//   Handshake: there is no handshake. o_valid_chg is a qualifier pulse only.
//   It is high for exactly one cycle, and that cycle is the one where
//   o_data_stable holds its new value for the first time.
//
//   Timing: the FSM decides a change on one edge. The output registers pick
//   up the decision on the following edge. A level seen first at sync edge 0
//   therefore appears on o_data_stable at edge SYNC_STAGES+DEB_CYCLES+1.
module key_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 20,
    parameter int CNT_W       = 20
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       i_data_in,
    output logic       o_data_stable,
    output logic       o_valid_chg,
`ifdef DEBOUNCE_EVT_CNT_EN
    output logic [7:0] o_evt_cnt,
`endif
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_sync;
    state_t                 state;
    logic [CNT_W-1:0]       counter;

    // Level that the output registers copy on the next edge. The stable level
    // is high in IDLE_HI, and also in CHK_LO, where a fall has not been
    // accepted yet.
    logic                   level_next;
    assign level_next = (state == IDLE_HI) || (state == CHK_LO);

    assign s_sync = sync[SYNC_STAGES-1];

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_data_in};
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE_LO;
            counter       <= '0;
            o_data_stable <= 1'b0;
            o_valid_chg   <= 1'b0;
            o_busy        <= 1'b0;
`ifdef DEBOUNCE_EVT_CNT_EN
            o_evt_cnt     <= 8'd0;
`endif
        end else begin
            // Output stage, one edge behind the FSM decision.
            o_data_stable <= level_next;
            o_valid_chg   <= (level_next != o_data_stable);
            o_busy        <= (state == CHK_HI) || (state == CHK_LO);
`ifdef DEBOUNCE_EVT_CNT_EN
            if (level_next != o_data_stable) begin
                o_evt_cnt <= o_evt_cnt + 8'd1;
            end
`endif
            case (state)
                IDLE_LO: begin
                    if (s_sync) begin
                        state   <= CHK_HI;
                        counter <= '0;
                    end
                end
                CHK_HI: begin
                    if (!s_sync) begin
                        state <= IDLE_LO;
                    end else if (counter == CNT_LAST) begin
                        state <= IDLE_HI;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                IDLE_HI: begin
                    if (!s_sync) begin
                        state   <= CHK_LO;
                        counter <= '0;
                    end
                end
                CHK_LO: begin
                    if (s_sync) begin
                        state <= IDLE_HI;
                    end else if (counter == CNT_LAST) begin
                        state <= IDLE_LO;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE_LO;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed bench for key_debounce with SYNC_STAGES=2, DEB_CYCLES=20 and a
//   10 ns clock. Inputs change on the falling edge. Outputs are sampled 1 ns
//   after the rising edge. Edge 0 is the first rising edge that samples a new
//   input level.
module tb_key_debounce;

    logic sclk  = 1'b0;
    logic rst_n = 1'b1;
    logic i_data_in = 1'b0;
    logic o_data_stable;
    logic o_valid_chg;
    logic o_busy;
`ifdef DEBOUNCE_EVT_CNT_EN
    logic [7:0] o_evt_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 sclk = ~sclk;

    key_debounce #(
        .SYNC_STAGES(2),
        .DEB_CYCLES (20),
        .CNT_W      (20)
    ) dut (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .i_data_in    (i_data_in),
        .o_data_stable(o_data_stable),
        .o_valid_chg  (o_valid_chg),
`ifdef DEBOUNCE_EVT_CNT_EN
        .o_evt_cnt    (o_evt_cnt),
`endif
        .o_busy       (o_busy)
    );

    // Watches max_cycles rising edges, starting at edge 0. It records when
    // o_data_stable first reaches target and counts pulses on o_valid_chg.
    // It also counts o_busy cycles before the change and any back-to-back pulses.
    task automatic measure(input int max_cycles, input logic target,
                           output int change_at, output int pulses,
                           output int pulse_at, output int busy_hi,
                           output int consec);
        logic prev_valid;
        change_at  = -1;
        pulses     = 0;
        pulse_at   = -1;
        busy_hi    = 0;
        consec     = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge sclk);
            #1;
            if (o_data_stable === target && change_at < 0) change_at = i;
            if (o_valid_chg === 1'b1) begin
                pulses++;
                pulse_at = i;
                if (prev_valid) consec++;
            end
            if (o_busy === 1'b1 && change_at < 0) busy_hi++;
            prev_valid = (o_valid_chg === 1'b1);
        end
    endtask

    task automatic test_reset;
        int bad_during;
        int bad_after;
        bad_during = 0;
        bad_after  = 0;
        i_data_in = 1'b0;
        #1 rst_n = 1'b0;
        repeat (10) begin
            @(posedge sclk);
            #1;
            if ({o_data_stable, o_valid_chg, o_busy} !== 3'b000) bad_during++;
        end
        @(negedge sclk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge sclk);
            #1;
            if ({o_data_stable, o_valid_chg, o_busy} !== 3'b000) bad_after++;
        end
        tests_run++;
        if (bad_during !== 0) begin
            tests_failed++;
            $display("FAIL reset_during: %0d nonzero samples, expected 0", bad_during);
        end
        tests_run++;
        if (bad_after !== 0) begin
            tests_failed++;
            $display("FAIL reset_after: %0d nonzero samples, expected 0", bad_after);
        end
    endtask

    task automatic test_rise;
        int change_at, pulses, pulse_at, busy_hi, consec;
        @(negedge sclk);
        i_data_in = 1'b1;
        measure(50, 1'b1, change_at, pulses, pulse_at, busy_hi, consec);
        tests_run++;
        if (change_at !== 23) begin
            tests_failed++;
            $display("FAIL rise_latency: got %0d, expected 23", change_at);
        end
        tests_run++;
        if (pulses !== 1 || pulse_at !== 23) begin
            tests_failed++;
            $display("FAIL rise_pulse: pulses %0d at %0d, expected 1 at 23", pulses, pulse_at);
        end
        tests_run++;
        if (busy_hi !== 20) begin
            tests_failed++;
            $display("FAIL rise_busy: busy cycles %0d, expected 20", busy_hi);
        end
        tests_run++;
        if (o_data_stable !== 1'b1 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rise_hold: stable %b busy %b, expected 1 0", o_data_stable, o_busy);
        end
    endtask

    task automatic test_fall;
        int change_at, pulses, pulse_at, busy_hi, consec;
        @(negedge sclk);
        i_data_in = 1'b0;
        measure(40, 1'b0, change_at, pulses, pulse_at, busy_hi, consec);
        tests_run++;
        if (change_at !== 23 || pulses !== 1 || pulse_at !== 23) begin
            tests_failed++;
            $display("FAIL fall: change %0d pulses %0d at %0d, expected 23 1 23",
                     change_at, pulses, pulse_at);
        end
        tests_run++;
        if (busy_hi !== 20) begin
            tests_failed++;
            $display("FAIL fall_busy: busy cycles %0d, expected 20", busy_hi);
        end
    endtask

    task automatic test_glitch;
        int stable_bad, pulses, busy_seen;
        stable_bad = 0;
        pulses     = 0;
        busy_seen  = 0;
        @(negedge sclk);
        i_data_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge sclk);
            #1;
            if (o_data_stable !== 1'b0) stable_bad++;
            if (o_valid_chg === 1'b1) pulses++;
            if (o_busy === 1'b1) busy_seen++;
            if (i == 4) i_data_in = 1'b0;   // high for edges 0..4 only
        end
        tests_run++;
        if (stable_bad !== 0 || pulses !== 0) begin
            tests_failed++;
            $display("FAIL glitch_reject: stable_bad %0d pulses %0d, expected 0 0",
                     stable_bad, pulses);
        end
        tests_run++;
        if (busy_seen == 0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy: busy cycles %0d final %b, expected >0 and 0",
                     busy_seen, o_busy);
        end
    endtask

    task automatic test_bounce;
        int bad;
        int change_at, pulses, pulse_at, busy_hi, consec;
        bad = 0;
        @(negedge sclk);
        for (int seg = 0; seg < 10; seg++) begin
            i_data_in = (seg % 2 == 0) ? 1'b1 : 1'b0;
            repeat (3) begin
                @(negedge sclk);
                if (o_data_stable !== 1'b0 || o_valid_chg !== 1'b0) bad++;
            end
        end
        i_data_in = 1'b1;
        measure(40, 1'b1, change_at, pulses, pulse_at, busy_hi, consec);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL bounce_reject: %0d bad samples, expected 0", bad);
        end
        tests_run++;
        if (change_at !== 23 || pulses !== 1 || consec !== 0) begin
            tests_failed++;
            $display("FAIL bounce_rise: change %0d pulses %0d consec %0d, expected 23 1 0",
                     change_at, pulses, consec);
        end
    endtask

    task automatic test_reset_mid;
        int change_at, pulses, pulse_at, busy_hi, consec;
        @(negedge sclk);
        i_data_in = 1'b0;
        repeat (8) @(negedge sclk);
        tests_run++;
        if (o_busy !== 1'b1 || o_data_stable !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_chk_lo: busy %b stable %b, expected 1 1", o_busy, o_data_stable);
        end
        i_data_in = 1'b1;
        rst_n     = 1'b0;
        #1;
        tests_run++;
        if ({o_data_stable, o_valid_chg, o_busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_reset_async: outputs %b, expected 000",
                     {o_data_stable, o_valid_chg, o_busy});
        end
        repeat (2) @(negedge sclk);
        tests_run++;
        if (o_data_stable !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_hold: stable %b, expected 0", o_data_stable);
        end
        rst_n = 1'b1;
        measure(40, 1'b1, change_at, pulses, pulse_at, busy_hi, consec);
        tests_run++;
        if (change_at !== 23 || pulses !== 1 || pulse_at !== 23) begin
            tests_failed++;
            $display("FAIL mid_reset_rerise: change %0d pulses %0d at %0d, expected 23 1 23",
                     change_at, pulses, pulse_at);
        end
    endtask

`ifdef DEBOUNCE_EVT_CNT_EN
    task automatic hold_level(input logic level, input int cycles);
        @(negedge sclk);
        i_data_in = level;
        repeat (cycles) @(negedge sclk);
    endtask

    task automatic pulse_reset;
        @(negedge sclk);
        i_data_in = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        repeat (5) @(negedge sclk);
    endtask

    task automatic test_evt_cnt;
        pulse_reset();
        tests_run++;
        if (o_evt_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL evt_reset: got %0d, expected 0", o_evt_cnt);
        end
        for (int p = 0; p < 3; p++) begin
            hold_level(1'b1, 30);
            hold_level(1'b0, 30);
        end
        for (int g = 0; g < 2; g++) begin
            hold_level(1'b1, 5);
            hold_level(1'b0, 30);
        end
        tests_run++;
        if (o_evt_cnt !== 8'd6) begin
            tests_failed++;
            $display("FAIL evt_pairs: got %0d, expected 6", o_evt_cnt);
        end
        pulse_reset();
        for (int p = 0; p < 128; p++) begin
            hold_level(1'b1, 26);
            hold_level(1'b0, 26);
        end
        tests_run++;
        if (o_evt_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL evt_wrap: got %0d, expected 0", o_evt_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_bounce();
        test_reset_mid();
`ifdef DEBOUNCE_EVT_CNT_EN
        test_evt_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
